// File: rtl/phy_tx_par2serial.sv
// rtl/phy_tx_par2serial.sv - byte-to-serial TX lane with comma framing
//
// Serializes one WIDTH-bit symbol per WIDTH cycles of clk_32f, MSB first.
// After reset, SYNC_CNT comma symbols (IDLE_SYM) frame the link. Payload is
// accepted only after that. Empty byte slots carry IDLE_SYM.
//
// Ports:
//   clk_32f   in   1      serial bit clock
//   reset     in   1      synchronous, active-high
//   data_in   in   WIDTH  parallel byte, sampled only on load edges
//   valid_in  in   1      data_in qualifier
//   data_out  out  1      registered serial bit, MSB first
//   active    out  1      framing complete, payload slots live
//   byte_cnt  out  16     payload bytes sent (only with PHY_TX_BYTE_CNT_EN)
//
// Optional feature macro: PHY_TX_BYTE_CNT_EN adds the byte_cnt output.

module phy_tx_par2serial #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
  parameter int              SYNC_CNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             data_out,
  output logic             active
`ifdef PHY_TX_BYTE_CNT_EN
  ,
  output logic [15:0]      byte_cnt
`endif
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SCW = (SYNC_CNT > 1) ? $clog2(SYNC_CNT) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_CNT - 1);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             data_out_d;
  logic             active_d;
  logic             load;
  logic [WIDTH-1:0] sym;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      sync_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      data_out   <= 1'b0;
      active     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      data_out   <= data_out_d;
      active     <= active_d;
    end
  end

  always_comb begin
    load       = (bit_cnt_q == '0);
    // Payload only goes out once framing is done; otherwise a comma fills the slot.
    sym        = (state_q == ST_ACTIVE && valid_in) ? data_in : IDLE_SYM;
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    active_d   = active;
    bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    data_out_d = sr_q[WIDTH-1];
    sr_d       = {sr_q[WIDTH-2:0], 1'b0};

    if (load) begin
      // MSB leaves immediately; the remaining bits queue up in sr.
      data_out_d = sym[WIDTH-1];
      sr_d       = {sym[WIDTH-2:0], 1'b0};
      if (state_q == ST_SYNC) begin
        // The last comma load flips to ACTIVE, so the next load samples payload.
        if (sync_cnt_q == SYNC_LAST) begin
          state_d  = ST_ACTIVE;
          active_d = 1'b1;
        end else begin
          sync_cnt_d = sync_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef PHY_TX_BYTE_CNT_EN
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      byte_cnt <= '0;
    end else if (load && state_q == ST_ACTIVE && valid_in) begin
      byte_cnt <= byte_cnt + 16'd1;
    end
  end
`else
  // Without the counter, the payload byte count is not tracked.
`endif

endmodule

// File: tb/tb_phy_tx_par2serial.sv
// tb/tb_phy_tx_par2serial.sv - scoreboard bench for phy_tx_par2serial

module tb_phy_tx_par2serial;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       active;
`ifdef PHY_TX_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  phy_tx_par2serial dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .active   (active)
`ifdef PHY_TX_BYTE_CNT_EN
    ,
    .byte_cnt (byte_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int          cyc;
    logic        d;
    logic        a;
    logic [15:0] bc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Reference framing state kept by the stimulus side.
  bit          st_active_m;
  int          sync_m;
  logic        act_m;
  logic [15:0] bc_m;

  always @(posedge clk_32f) cyc <= cyc + 1;

  always @(negedge clk_32f) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      bad++;
      total++;
      $display("FAIL missed_slot cyc=%0d actual=unchecked required=checked", q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (data_out !== e.d) begin
        bad++;
        $display("FAIL data_out cyc=%0d actual=%b required=%b", cyc, data_out, e.d);
      end
      total++;
      if (active !== e.a) begin
        bad++;
        $display("FAIL active cyc=%0d actual=%b required=%b", cyc, active, e.a);
      end
`ifdef PHY_TX_BYTE_CNT_EN
      total++;
      if (byte_cnt !== e.bc) begin
        bad++;
        $display("FAIL byte_cnt cyc=%0d actual=%0d required=%0d", cyc, byte_cnt, e.bc);
      end
`endif
    end
  end

  task automatic push_sym(input logic [7:0] s, input int nb);
    exp_t e;
    for (int k = 0; k < nb; k++) begin
      e.cyc = cyc + 1 + k;
      e.d   = s[7-k];
      e.a   = act_m;
      e.bc  = bc_m;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    reset       = 1'b1;
    st_active_m = 1'b0;
    sync_m      = 0;
    act_m       = 1'b0;
    bc_m        = 16'd0;
    for (int k = 0; k < n; k++) begin
      e.cyc = cyc + 1 + k;
      e.d   = 1'b0;
      e.a   = 1'b0;
      e.bc  = 16'd0;
      q.push_back(e);
    end
    repeat (n) begin
      @(posedge clk_32f);
      #1;
    end
    reset = 1'b0;
  endtask

  // One byte slot starting at the next edge. nb < 8 cuts the slot short;
  // chg > 0 swaps data_in to d2 once bit_cnt has reached chg.
  task automatic slot(input logic [7:0] d, input logic v, input int nb,
                      input int chg, input logic [7:0] d2);
    logic [7:0] s;
    data_in  = d;
    valid_in = v;
    if (st_active_m) begin
      s     = v ? d : 8'hBC;
      act_m = 1'b1;
      if (v) bc_m = bc_m + 16'd1;
    end else begin
      s = 8'hBC;
      if (sync_m == 3) begin
        act_m       = 1'b1;
        st_active_m = 1'b1;
      end else begin
        sync_m++;
      end
    end
    push_sym(s, nb);
    for (int i = 0; i < nb; i++) begin
      @(posedge clk_32f);
      #1;
      if (i + 1 == chg) data_in = d2;
    end
  endtask

  initial begin
    int guard;
    reset    = 1'b1;
    data_in  = 8'h00;
    valid_in = 1'b0;
    @(posedge clk_32f);
    #1;

    do_reset(3);
    repeat (4) slot(8'h00, 1'b0, 8, 0, 8'h00);
    slot(8'h00, 1'b0, 8, 0, 8'h00);
    slot(8'hA5, 1'b1, 8, 0, 8'h00);

    slot(8'hFF, 1'b1, 8, 4, 8'h00);
    slot(8'hFF, 1'b0, 8, 0, 8'h00);
    slot(8'hFF, 1'b1, 8, 0, 8'h00);
    slot(8'h5A, 1'b0, 8, 0, 8'h00);

    slot(8'hA5, 1'b1, 5, 0, 8'h00);
    do_reset(2);
    repeat (4) slot(8'h3C, 1'b1, 8, 0, 8'h00);
    slot(8'h3C, 1'b1, 8, 0, 8'h00);

`ifdef PHY_TX_BYTE_CNT_EN
    @(negedge clk_32f);
    #1;
    force dut.byte_cnt = 16'hFFFF;
    #1;
    release dut.byte_cnt;
    bc_m = 16'hFFFF;
    slot(8'h81, 1'b1, 8, 0, 8'h00);
    slot(8'h00, 1'b0, 8, 0, 8'h00);
`endif

    valid_in = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      @(posedge clk_32f);
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d_left required=0_left", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
